// File: rtl/calc_entry_engine.sv
// calc_entry_engine: consumer side of the keypad decoder. Turns held key
// levels into one-shot events, builds two decimal operands, and evaluates
// add/sub/mul in a single cycle or divide with a 14-step restoring divider.
//
// Key interface semantics: numPressed/optPressed/submit are levels held for
// as long as the key is down; num/opt are only meaningful while their
// pressed flag is high. A key produces exactly one event, on the cycle its
// level is first seen high after being low. Releasing a key produces no event.
module calc_entry_engine #(
  parameter int DIGITS = 4,
  parameter int VMAX   = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  num,
  input  logic        numPressed,
  input  logic [2:0]  opt,
  input  logic        optPressed,
  input  logic        submit,
  output logic [13:0] value,
  output logic [2:0]  opCode,
  output logic [2:0]  digitCount,
  output logic        resultValid,
  output logic        busy,
  output logic        error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_DIVIDE  = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_t;

  localparam logic [2:0]  OP_NONE  = 3'd0;
  localparam logic [2:0]  OP_ADD   = 3'd1;
  localparam logic [2:0]  OP_SUB   = 3'd2;
  localparam logic [2:0]  OP_MUL   = 3'd3;
  localparam logic [2:0]  OP_DIV   = 3'd4;
  localparam logic [2:0]  OP_CLEAR = 3'd5;
  localparam logic [3:0]  DIV_LAST = 4'd13;  // 14 iterations, one per operand bit
  localparam logic [14:0] VMAX15   = 15'(VMAX);
  localparam logic [26:0] VMAX27   = 27'(VMAX);
  localparam logic [2:0]  DIGITS3  = 3'(DIGITS);

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [13:0] a_q, a_d;
  logic [13:0] b_q, b_d;
  logic [13:0] result_q, result_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  count_q, count_d;
  logic [13:0] div_rem_q, div_rem_d;
  logic [13:0] div_quo_q, div_quo_d;
  logic [3:0]  div_cnt_q, div_cnt_d;
  // Input pipeline bit layout: {submit, optPressed, opt[2:0], numPressed, num[3:0]}
  logic [9:0]  in_s1_q, in_s1_d;
  logic [9:0]  in_s2_q, in_s2_d;

  // Two-stage input capture: s1 is the sampled level, s2 its previous value
  always_comb begin
    in_s1_d = {submit, optPressed, opt, numPressed, num};
    in_s2_d = in_s1_q;
  end

  // ---------------------------------------------------------------------
  // Event detection and priority (clear > submit > operator > digit)
  // ---------------------------------------------------------------------
  logic [3:0] num_s1;
  logic [2:0] opt_s1;
  logic       num_rise, opt_rise, sub_rise;
  logic       op_code_ok;
  logic       clr_evt, sub_evt, op_evt, dig_evt;

  // Rising-edge events from the s1/s2 pair, then priority resolution
  always_comb begin
    num_s1     = in_s1_q[3:0];
    opt_s1     = in_s1_q[7:5];
    num_rise   = in_s1_q[4] & ~in_s2_q[4];
    opt_rise   = in_s1_q[8] & ~in_s2_q[8];
    sub_rise   = in_s1_q[9] & ~in_s2_q[9];
    op_code_ok = (opt_s1 >= OP_ADD) && (opt_s1 <= OP_DIV);
    clr_evt    = opt_rise && (opt_s1 == OP_CLEAR);
    sub_evt    = sub_rise && !clr_evt;
    op_evt     = opt_rise && op_code_ok && !sub_rise;
    dig_evt    = num_rise && !clr_evt && !sub_rise && !(opt_rise && op_code_ok);
  end

  // ---------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------
  logic [13:0] a_acc, b_acc;
  logic [14:0] sum;
  logic [13:0] diff;
  logic [26:0] prod;
  logic [14:0] rem_shift;
  logic [13:0] quo_shift;
  logic [13:0] rem_next, quo_next;

  // Decimal accumulate, one-cycle arithmetic and one restoring divide step
  always_comb begin
    a_acc     = 14'((a_q << 3) + (a_q << 1) + {10'd0, num_s1});
    b_acc     = 14'((b_q << 3) + (b_q << 1) + {10'd0, num_s1});
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = a_q - b_q;
    prod      = 27'(a_q) * 27'(b_q);
    rem_shift = {div_rem_q, div_quo_q[13]};
    quo_shift = {div_quo_q[12:0], 1'b0};
    if (rem_shift >= {1'b0, b_q}) begin
      rem_next = 14'(rem_shift - {1'b0, b_q});
      quo_next = quo_shift | 14'd1;
    end else begin
      rem_next = rem_shift[13:0];
      quo_next = quo_shift;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  // All state and datapath flops, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      op_q      <= OP_NONE;
      count_q   <= '0;
      div_rem_q <= '0;
      div_quo_q <= '0;
      div_cnt_q <= '0;
      in_s1_q   <= '0;
      in_s2_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      op_q      <= op_d;
      count_q   <= count_d;
      div_rem_q <= div_rem_d;
      div_quo_q <= div_quo_d;
      div_cnt_q <= div_cnt_d;
      in_s1_q   <= in_s1_d;
      in_s2_q   <= in_s2_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state and datapath update
  // ---------------------------------------------------------------------
  // Clear overrides everything; otherwise each state reacts to its events
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    op_d      = op_q;
    count_d   = count_q;
    div_rem_d = div_rem_q;
    div_quo_d = div_quo_q;
    div_cnt_d = div_cnt_q;

    if (clr_evt) begin
      state_d   = ST_ENTER_A;
      a_d       = '0;
      b_d       = '0;
      count_d   = '0;
      op_d      = OP_NONE;
      div_cnt_d = '0;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (sub_evt) begin
            result_d = a_q;
            state_d  = ST_DONE;
          end else if (op_evt) begin
            op_d    = opt_s1;
            b_d     = '0;
            count_d = '0;
            state_d = ST_ENTER_B;
          end else if (dig_evt && (count_q < DIGITS3)) begin
            a_d     = a_acc;
            count_d = count_q + 3'd1;
          end
        end

        ST_ENTER_B: begin
          if (sub_evt) begin
            case (op_q)
              OP_ADD: begin
                if (sum > VMAX15) state_d = ST_ERROR;
                else begin
                  result_d = sum[13:0];
                  state_d  = ST_DONE;
                end
              end
              OP_SUB: begin
                if (a_q < b_q) state_d = ST_ERROR;
                else begin
                  result_d = diff;
                  state_d  = ST_DONE;
                end
              end
              OP_MUL: begin
                if (prod > VMAX27) state_d = ST_ERROR;
                else begin
                  result_d = prod[13:0];
                  state_d  = ST_DONE;
                end
              end
              OP_DIV: begin
                if (b_q == '0) state_d = ST_ERROR;
                else begin
                  div_rem_d = '0;
                  div_quo_d = a_q;
                  div_cnt_d = '0;
                  state_d   = ST_DIVIDE;
                end
              end
              default: state_d = ST_ERROR;
            endcase
          end else if (op_evt) begin
            // Operator may be changed only before any digit of B is typed
            if (count_q == '0) op_d = opt_s1;
          end else if (dig_evt && (count_q < DIGITS3)) begin
            b_d     = b_acc;
            count_d = count_q + 3'd1;
          end
        end

        ST_DIVIDE: begin
          div_rem_d = rem_next;
          div_quo_d = quo_next;
          div_cnt_d = div_cnt_q + 4'd1;
          if (div_cnt_q == DIV_LAST) begin
            result_d = quo_next;
            state_d  = ST_DONE;
          end
        end

        ST_DONE: begin
          if (op_evt) begin
            // Chain: previous result becomes the left operand
            a_d     = result_q;
            b_d     = '0;
            count_d = '0;
            op_d    = opt_s1;
            state_d = ST_ENTER_B;
          end else if (dig_evt) begin
            a_d     = {10'd0, num_s1};
            count_d = 3'd1;
            op_d    = OP_NONE;
            state_d = ST_ENTER_A;
          end
        end

        ST_ERROR: ;

        default: state_d = ST_ENTER_A;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  // Display value and status flags decoded from the current state
  always_comb begin
    value       = '0;
    resultValid = 1'b0;
    busy        = 1'b0;
    error       = 1'b0;
    case (state_q)
      ST_ENTER_A: value = a_q;
      ST_ENTER_B: value = b_q;
      ST_DONE: begin
        value       = result_q;
        resultValid = 1'b1;
      end
      ST_DIVIDE: busy  = 1'b1;
      ST_ERROR:  error = 1'b1;
      default:   value = '0;
    endcase
    opCode     = op_q;
    digitCount = count_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_calc_entry_engine.sv
// Directed bench for calc_entry_engine with hand-computed expectations.
module tb_calc_entry_engine;

  logic        clk;
  logic        reset;
  logic [3:0]  num;
  logic        numPressed;
  logic [2:0]  opt;
  logic        optPressed;
  logic        submit;
  logic [13:0] value;
  logic [2:0]  opCode;
  logic [2:0]  digitCount;
  logic        resultValid;
  logic        busy;
  logic        error;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  calc_entry_engine #(.DIGITS(4), .VMAX(9999)) dut (
    .clk        (clk),
    .reset      (reset),
    .num        (num),
    .numPressed (numPressed),
    .opt        (opt),
    .optPressed (optPressed),
    .submit     (submit),
    .value      (value),
    .opCode     (opCode),
    .digitCount (digitCount),
    .resultValid(resultValid),
    .busy       (busy),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks: each press holds the key two cycles, then releases two cycles
  task automatic press_digit(input logic [3:0] d);
    @(negedge clk); num = d; numPressed = 1'b1;
    repeat (2) @(negedge clk);
    numPressed = 1'b0; num = 4'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_op(input logic [2:0] o);
    @(negedge clk); opt = o; optPressed = 1'b1;
    repeat (2) @(negedge clk);
    optPressed = 1'b0; opt = 3'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press_submit();
    @(negedge clk); submit = 1'b1;
    repeat (2) @(negedge clk);
    submit = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic enter_number(input int v);
    int d[4];
    int n;
    int t;
    n = 0;
    t = v;
    if (t == 0) begin
      d[0] = 0; n = 1;
    end
    while (t > 0 && n < 4) begin
      d[n] = t % 10; t = t / 10; n++;
    end
    for (int i = n - 1; i >= 0; i--) press_digit(4'(d[i]));
  endtask

  int busy_cnt;
  int got_done;

  initial begin
    reset = 1'b0; num = 4'd0; numPressed = 1'b0; opt = 3'd0;
    optPressed = 1'b0; submit = 1'b0;
    #1;
    check("rst_value", value, 0);
    check("rst_opcode", opCode, 0);
    check("rst_count", digitCount, 0);
    check("rst_valid", resultValid, 0);
    check("rst_busy", busy, 0);
    check("rst_error", error, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1,2,3,4,5 -> 1234, fifth digit dropped
    enter_number(1234);
    press_digit(4'd5);
    check("digits_value", value, 1234);
    check("digits_count", digitCount, 4);
    press_op(3'd5);
    check("clr_value", value, 0);
    check("clr_count", digitCount, 0);

    // 12 + 30, resultValid exactly two edges after submit rises
    enter_number(12);
    press_op(3'd1);
    check("add_opcode", opCode, 1);
    check("add_enterb_count", digitCount, 0);
    enter_number(30);
    check("add_b_value", value, 30);
    @(negedge clk); submit = 1'b1;
    @(posedge clk); #1;
    check("add_valid_edge1", resultValid, 0);
    @(posedge clk); #1;
    check("add_valid_edge2", resultValid, 1);
    check("add_value", value, 42);
    @(negedge clk); submit = 1'b0;
    repeat (2) @(negedge clk);
    press_op(3'd5);

    // 100 / 7: busy for 14 cycles then quotient 14
    enter_number(100);
    press_op(3'd4);
    enter_number(7);
    @(negedge clk); submit = 1'b1;
    @(posedge clk); #1;
    check("div_busy_edgeN", busy, 0);
    @(posedge clk); #1;
    check("div_busy_edgeN1", busy, 1);
    busy_cnt = 1;
    got_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (i == 0) submit = 1'b0;
      if (busy) busy_cnt++;
      if (resultValid) begin
        got_done = 1;
        break;
      end
    end
    check("div_done_seen", got_done, 1);
    check("div_busy_cycles", busy_cnt, 14);
    check("div_value", value, 14);
    check("div_busy_after", busy, 0);
    repeat (2) @(negedge clk);
    press_op(3'd5);

    // 5 - 9 underflows
    enter_number(5);
    press_op(3'd2);
    enter_number(9);
    press_submit();
    check("sub_err_flag", error, 1);
    check("sub_err_value", value, 0);
    check("sub_err_valid", resultValid, 0);
    press_digit(4'd3);
    check("err_digit_ignored", error, 1);
    press_op(3'd5);
    check("sub_clr_error", error, 0);
    check("sub_clr_value", value, 0);
    check("sub_clr_state", dbg_state, 0);

    // 9999 * 2 overflows
    enter_number(9999);
    press_op(3'd3);
    enter_number(2);
    press_submit();
    check("mul_ovf_error", error, 1);
    press_op(3'd5);

    // 8 / 0
    enter_number(8);
    press_op(3'd4);
    enter_number(0);
    press_submit();
    check("div0_error", error, 1);
    check("div0_busy", busy, 0);
    press_op(3'd5);

    // 6 * 7 = 42, then chained + 8 = 50
    enter_number(6);
    press_op(3'd3);
    enter_number(7);
    press_submit();
    check("mul_value", value, 42);
    press_op(3'd1);
    check("chain_state", dbg_state, 1);
    check("chain_opcode", opCode, 1);
    check("chain_b_value", value, 0);
    enter_number(8);
    press_submit();
    check("chain_value", value, 50);
    check("chain_valid", resultValid, 1);
    press_op(3'd5);

    // submit held 20 cycles: 3 + 4 = 7
    enter_number(3);
    press_op(3'd1);
    enter_number(4);
    @(negedge clk); submit = 1'b1;
    repeat (20) @(negedge clk);
    submit = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_submit_value", value, 7);
    check("hold_submit_valid", resultValid, 1);
    // digit 5 held 20 cycles from DONE: single event
    @(negedge clk); num = 4'd5; numPressed = 1'b1;
    repeat (20) @(negedge clk);
    numPressed = 1'b0;
    repeat (2) @(negedge clk);
    check("hold_digit_value", value, 5);
    check("hold_digit_count", digitCount, 1);
    check("hold_digit_opcode", opCode, 0);
    press_op(3'd5);

    // clear during divide
    enter_number(100);
    press_op(3'd4);
    enter_number(7);
    press_submit();
    check("abort_busy_before", busy, 1);
    @(negedge clk); opt = 3'd5; optPressed = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_edgeN", busy, 1);
    @(posedge clk); #1;
    check("abort_busy_edgeN1", busy, 0);
    check("abort_state", dbg_state, 0);
    check("abort_value", value, 0);
    check("abort_opcode", opCode, 0);
    @(negedge clk); optPressed = 1'b0; opt = 3'd0;
    repeat (20) @(negedge clk);
    check("abort_no_result", resultValid, 0);

    // async reset pulse mid-entry
    enter_number(12);
    press_op(3'd1);
    press_digit(4'd3);
    check("pre_rst_value", value, 3);
    check("pre_rst_opcode", opCode, 1);
    @(negedge clk); #2; reset = 1'b0;
    #1;
    check("async_rst_value", value, 0);
    check("async_rst_opcode", opCode, 0);
    check("async_rst_count", digitCount, 0);
    check("async_rst_state", dbg_state, 0);
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    press_digit(4'd9);
    check("post_rst_value", value, 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
